controle_jogo: RTL and testbench

Game-flow controller that sequences the entities datapath (ship, enemy row, projectiles). It owns the `pausa` and `reiniciarJogo` controls and replaces the free-running movement clock divider with a single-cycle tick enable. It tracks the wave number (`fase`) and the ESPERA/REINICIA/JOGANDO/PAUSADO/VITORIA/DERROTA state machine. It sits between the board keys and the entities block.

---
 rtl/jogo_pkg.sv | 29 ++
 rtl/controle_jogo_if.sv | 16 +
 rtl/sincroniza_botao.sv | 24 ++
 rtl/controle_jogo.sv | 123 ++++++++++++
 tb/tb_controle_jogo.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the game-flow controller: state encoding, default
// enemy count, wave ceiling and the per-wave tick period calculation.
package jogo_pkg;

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    REINICIA = 3'd1,
    JOGANDO  = 3'd2,
    PAUSADO  = 3'd3,
    VITORIA  = 3'd4,
    DERROTA  = 3'd5
  } estado_t;

  localparam int         N_INIMIGOS_DEF = 5;
  localparam logic [3:0] FASE_MAX       = 4'd15;

  // Period shrinks by step per wave above 1 and floors at lim; the floor test
  // happens before the subtraction so the result can never underflow.
  function automatic logic [31:0] calc_periodo(input logic [3:0]  fase,
                                               input logic [31:0] div,
                                               input logic [31:0] step,
                                               input logic [31:0] lim);
    logic [31:0] prod;
    prod = ({28'd0, fase} - 32'd1) * step;
    if (prod >= div - lim) return lim;
    else                   return div - prod;
  endfunction

endpackage

// File: rtl/controle_jogo_if.sv
// Control link between the game-flow controller (master) and the entities
// datapath (slave): freeze/restart/tick downstream, loss and alive flags upstream.
interface controle_jogo_if import jogo_pkg::*; #(
  parameter int N_INIMIGOS = N_INIMIGOS_DEF
);
  logic                  pausa;
  logic                  reiniciarJogo;
  logic                  tick_mv;
  logic                  perdeu;
  logic [N_INIMIGOS-1:0] inimigo_vivo_array;

  modport master (output pausa, reiniciarJogo, tick_mv,
                  input  perdeu, inimigo_vivo_array);
  modport slave  (input  pausa, reiniciarJogo, tick_mv,
                  output perdeu, inimigo_vivo_array);
endinterface

// File: rtl/sincroniza_botao.sv
// Two-flop synchronizer for a raw key followed by a registered rising-edge
// detector; every low-to-high transition yields exactly one pulse cycle.
module sincroniza_botao (
  input  logic clk,
  input  logic rst,
  input  logic botao,
  output logic pulso
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulso <= 1'b0;
    end else begin
      s1    <= botao;
      s2    <= s1;
      s3    <= s2;
      pulso <= s2 & ~s3;
    end
  end
endmodule

// File: rtl/controle_jogo.sv
// Game-flow controller: key handling, state machine, wave tracking and the
// movement tick. Define CONTROLE_FASES_EN for wave progression and speed-up.
module controle_jogo import jogo_pkg::*; #(
  parameter int          N_INIMIGOS     = N_INIMIGOS_DEF,
  parameter int unsigned TICK_DIV       = 320000,
  parameter int unsigned TICK_STEP      = 20000,
  parameter int unsigned TICK_MIN       = 100000,
  parameter int unsigned RESTART_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES    = 50000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  key_start,
  input  logic                  key_pausa,
  controle_jogo_if.master       ent,
  output logic [2:0]            estado,
  output logic [3:0]            fase
);
  localparam logic [31:0] DIV32    = 32'(TICK_DIV);
  localparam logic [31:0] RST_LAST = 32'(RESTART_CYCLES - 1);

  logic        ini_p, pau_p;
  estado_t     st, st_n;
  logic [3:0]  fase_r, fase_n;
  logic [31:0] tick_cnt, tick_cnt_n, hold_cnt, hold_cnt_n, periodo;
  logic        pausa_n, reinic_n, tick_n;
  logic        sem_inimigos;

  sincroniza_botao u_sinc_start (.clk(CLOCK_50), .rst(reset), .botao(key_start), .pulso(ini_p));
  sincroniza_botao u_sinc_pausa (.clk(CLOCK_50), .rst(reset), .botao(key_pausa), .pulso(pau_p));

  assign sem_inimigos = (ent.inimigo_vivo_array == {N_INIMIGOS{1'b0}});
  assign estado       = st;
  assign fase         = fase_r;

`ifdef CONTROLE_FASES_EN
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  logic [31:0] periodo_n;
`endif

  always_comb begin
    st_n       = st;
    fase_n     = fase_r;
    tick_cnt_n = tick_cnt;
    hold_cnt_n = (st == REINICIA || st == VITORIA) ? hold_cnt + 32'd1 : 32'd0;
    tick_n     = 1'b0;
`ifdef CONTROLE_FASES_EN
    periodo_n  = periodo;
`endif
    case (st)
      ESPERA:   if (ini_p) begin fase_n = 4'd1; st_n = REINICIA; end
      REINICIA: if (hold_cnt == RST_LAST) st_n = JOGANDO;
      JOGANDO: begin
        if (tick_cnt == periodo - 32'd1) begin
          tick_cnt_n = 32'd0;
          tick_n     = 1'b1;
        end else begin
          tick_cnt_n = tick_cnt + 32'd1;
        end
        if (ent.perdeu)    st_n = DERROTA;
        else if (sem_inimigos) st_n = VITORIA;
        else if (pau_p)    st_n = PAUSADO;
      end
      PAUSADO: begin
        if (ini_p)      begin fase_n = 4'd1; st_n = REINICIA; end
        else if (pau_p) st_n = JOGANDO;
      end
`ifdef CONTROLE_FASES_EN
      VITORIA: if (hold_cnt == HOLD_LAST) begin
        fase_n = (fase_r >= FASE_MAX) ? FASE_MAX : fase_r + 4'd1;
        st_n   = REINICIA;
      end
`else
      VITORIA:  if (ini_p) st_n = REINICIA;
`endif
      DERROTA:  if (ini_p) begin fase_n = 4'd1; st_n = REINICIA; end
      default:  st_n = ESPERA;
    endcase

    if (st_n != st) hold_cnt_n = 32'd0;
    if (st_n == REINICIA && st != REINICIA) begin
      tick_cnt_n = 32'd0;
`ifdef CONTROLE_FASES_EN
      periodo_n  = calc_periodo(fase_n, DIV32, 32'(TICK_STEP), 32'(TICK_MIN));
`endif
    end

    // Outputs follow the next state so they line up with estado.
    pausa_n  = (st_n != JOGANDO);
    reinic_n = (st_n == REINICIA);
    tick_n   = tick_n & (st_n == JOGANDO);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      st                <= ESPERA;
      fase_r            <= 4'd1;
      tick_cnt          <= 32'd0;
      hold_cnt          <= 32'd0;
      ent.pausa         <= 1'b1;
      ent.reiniciarJogo <= 1'b0;
      ent.tick_mv       <= 1'b0;
    end else begin
      st                <= st_n;
      fase_r            <= fase_n;
      tick_cnt          <= tick_cnt_n;
      hold_cnt          <= hold_cnt_n;
      ent.pausa         <= pausa_n;
      ent.reiniciarJogo <= reinic_n;
      ent.tick_mv       <= tick_n;
    end
  end

`ifdef CONTROLE_FASES_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) periodo <= DIV32;
    else       periodo <= periodo_n;
  end
`else
  assign periodo = DIV32;
`endif

endmodule

// File: tb/tb_controle_jogo.sv
// Directed bench for controle_jogo with small timing parameters; covers both
// builds, selecting the wave scenario on CONTROLE_FASES_EN.
module tb_controle_jogo;
  logic       clk = 1'b0;
  logic       rst;
  logic       key_start, key_pausa;
  logic [2:0] estado;
  logic [3:0] fase;
  int         n_vec = 0;
  int         n_err = 0;

  controle_jogo_if #(.N_INIMIGOS(5)) ent ();

  controle_jogo #(.N_INIMIGOS(5), .TICK_DIV(8), .TICK_STEP(2), .TICK_MIN(4),
                  .RESTART_CYCLES(4), .HOLD_CYCLES(10)) dut (
    .CLOCK_50(clk), .reset(rst), .key_start(key_start), .key_pausa(key_pausa),
    .ent(ent.master), .estado(estado), .fase(fase));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_start = 1'b0; key_pausa = 1'b0;
    ent.perdeu = 1'b0; ent.inimigo_vivo_array = 5'b11111;
    step(); step();
    n_vec++;
    if (estado !== 3'd0 || ent.pausa !== 1'b1 || ent.reiniciarJogo !== 1'b0 ||
        ent.tick_mv !== 1'b0 || fase !== 4'd1) begin
      n_err++;
      $display("FAIL reset_vals: got estado=%0d pausa=%b reinic=%b tick=%b fase=%0d expected 0 1 0 0 1",
               estado, ent.pausa, ent.reiniciarJogo, ent.tick_mv, fase);
    end
    rst = 1'b0;
    step(); step();
    n_vec++;
    if (estado !== 3'd0 || ent.pausa !== 1'b1) begin
      n_err++;
      $display("FAIL idle_espera: got estado=%0d pausa=%b expected 0 1", estado, ent.pausa);
    end
  endtask

  task automatic test_start();
    key_start = 1'b1;
    step();                      // edge n
    key_start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      n_vec++;
      if (estado !== 3'd0) begin
        n_err++; $display("FAIL start_latency edge n+%0d: got estado=%0d expected 0", k, estado);
      end
    end
    step();                      // edge n+3
    n_vec++;
    if (estado !== 3'd1 || ent.reiniciarJogo !== 1'b1 || ent.pausa !== 1'b1 || fase !== 4'd1) begin
      n_err++;
      $display("FAIL start_reinicia: got estado=%0d reinic=%b pausa=%b fase=%0d expected 1 1 1 1",
               estado, ent.reiniciarJogo, ent.pausa, fase);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_vec++;
      if (estado !== 3'd1 || ent.reiniciarJogo !== 1'b1) begin
        n_err++;
        $display("FAIL reinic_len cycle %0d: got estado=%0d reinic=%b expected 1 1", k, estado, ent.reiniciarJogo);
      end
    end
    step();
    n_vec++;
    if (estado !== 3'd2 || ent.pausa !== 1'b0 || ent.reiniciarJogo !== 1'b0) begin
      n_err++;
      $display("FAIL enter_jogando: got estado=%0d pausa=%b reinic=%b expected 2 0 0",
               estado, ent.pausa, ent.reiniciarJogo);
    end
    for (int k = 1; k <= 16; k++) begin
      logic exp_t;
      exp_t = ((k % 8) == 0);
      step();
      n_vec++;
      if (ent.tick_mv !== exp_t) begin
        n_err++; $display("FAIL tick_period8 k=%0d: got %b expected %b", k, ent.tick_mv, exp_t);
      end
    end
  endtask

  // Entered right after a tick edge (counter 0); pause pulse lands while counter is 5.
  task automatic test_pause();
    step(); step();
    key_pausa = 1'b1;
    step();
    key_pausa = 1'b0;
    step(); step(); step();
    n_vec++;
    if (estado !== 3'd3 || ent.pausa !== 1'b1 || ent.tick_mv !== 1'b0) begin
      n_err++;
      $display("FAIL pause_enter: got estado=%0d pausa=%b tick=%b expected 3 1 0", estado, ent.pausa, ent.tick_mv);
    end
    for (int k = 1; k <= 100; k++) begin
      step();
      n_vec++;
      if (ent.tick_mv !== 1'b0 || estado !== 3'd3) begin
        n_err++;
        $display("FAIL pause_hold k=%0d: got tick=%b estado=%0d expected 0 3", k, ent.tick_mv, estado);
      end
    end
    key_pausa = 1'b1;
    step();
    key_pausa = 1'b0;
    step(); step(); step();
    n_vec++;
    if (estado !== 3'd2 || ent.pausa !== 1'b0 || ent.tick_mv !== 1'b0) begin
      n_err++;
      $display("FAIL resume: got estado=%0d pausa=%b tick=%b expected 2 0 0", estado, ent.pausa, ent.tick_mv);
    end
    step();
    n_vec++;
    if (ent.tick_mv !== 1'b0) begin
      n_err++; $display("FAIL resume_tick+1: got %b expected 0", ent.tick_mv);
    end
    step();
    n_vec++;
    if (ent.tick_mv !== 1'b1) begin
      n_err++; $display("FAIL resume_tick+2: got %b expected 1", ent.tick_mv);
    end
  endtask

  task automatic test_derrota_prioridade();
    ent.inimigo_vivo_array = 5'b00000;
    ent.perdeu = 1'b1;
    step();
    n_vec++;
    if (estado !== 3'd5 || fase !== 4'd1 || ent.pausa !== 1'b1) begin
      n_err++;
      $display("FAIL lose_over_win: got estado=%0d fase=%0d pausa=%b expected 5 1 1", estado, fase, ent.pausa);
    end
    ent.perdeu = 1'b0;
    ent.inimigo_vivo_array = 5'b11111;
    for (int k = 0; k < 5; k++) step();
    n_vec++;
    if (estado !== 3'd5 || ent.tick_mv !== 1'b0) begin
      n_err++; $display("FAIL derrota_hold: got estado=%0d tick=%b expected 5 0", estado, ent.tick_mv);
    end
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    step(); step(); step();
    n_vec++;
    if (estado !== 3'd1 || fase !== 4'd1) begin
      n_err++; $display("FAIL derrota_restart: got estado=%0d fase=%0d expected 1 1", estado, fase);
    end
    for (int k = 0; k < 4; k++) step();
    n_vec++;
    if (estado !== 3'd2) begin
      n_err++; $display("FAIL derrota_rejoga: got estado=%0d expected 2", estado);
    end
  endtask

`ifdef CONTROLE_FASES_EN
  // From JOGANDO: win, hold VITORIA 10 cycles, restart with the next wave.
  task automatic win_wave(input logic [3:0] f_exp, input int p_exp);
    ent.inimigo_vivo_array = 5'b00000;
    step();
    n_vec++;
    if (estado !== 3'd4 || ent.pausa !== 1'b1) begin
      n_err++; $display("FAIL vitoria_enter f=%0d: got estado=%0d pausa=%b expected 4 1", f_exp, estado, ent.pausa);
    end
    ent.inimigo_vivo_array = 5'b11111;
    for (int k = 0; k < 9; k++) step();
    n_vec++;
    if (estado !== 3'd4) begin
      n_err++; $display("FAIL vitoria_hold f=%0d: got estado=%0d expected 4", f_exp, estado);
    end
    step();
    n_vec++;
    if (estado !== 3'd1 || fase !== f_exp) begin
      n_err++; $display("FAIL vitoria_next: got estado=%0d fase=%0d expected 1 %0d", estado, fase, f_exp);
    end
    for (int k = 0; k < 4; k++) step();
    for (int k = 1; k <= p_exp; k++) begin
      logic exp_t;
      exp_t = (k == p_exp);
      step();
      n_vec++;
      if (ent.tick_mv !== exp_t) begin
        n_err++;
        $display("FAIL wave_period f=%0d k=%0d: got %b expected %b", f_exp, k, ent.tick_mv, exp_t);
      end
    end
  endtask

  task automatic test_fases();
    int f, p;
    for (int w = 1; w <= 15; w++) begin
      f = (w + 1 > 15) ? 15 : w + 1;
      p = ((f - 1) * 2 >= 4) ? 4 : 8 - (f - 1) * 2;
      win_wave(4'(f), p);
    end
  endtask
`else
  task automatic test_vitoria_sem_fases();
    ent.inimigo_vivo_array = 5'b00000;
    step();
    ent.inimigo_vivo_array = 5'b11111;
    for (int k = 0; k < 30; k++) step();
    n_vec++;
    if (estado !== 3'd4 || fase !== 4'd1) begin
      n_err++; $display("FAIL vitoria_indef: got estado=%0d fase=%0d expected 4 1", estado, fase);
    end
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    step(); step(); step();
    n_vec++;
    if (estado !== 3'd1 || fase !== 4'd1) begin
      n_err++; $display("FAIL vitoria_restart: got estado=%0d fase=%0d expected 1 1", estado, fase);
    end
    for (int k = 0; k < 4; k++) step();
    for (int k = 1; k <= 8; k++) begin
      logic exp_t;
      exp_t = (k == 8);
      step();
      n_vec++;
      if (ent.tick_mv !== exp_t) begin
        n_err++; $display("FAIL fixed_period k=%0d: got %b expected %b", k, ent.tick_mv, exp_t);
      end
    end
  endtask
`endif

  task automatic test_reset_async();
    ent.perdeu = 1'b1;
    step();
    ent.perdeu = 1'b0;
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    step(); step(); step();
    step(); step();
    n_vec++;
    if (estado !== 3'd1 || ent.reiniciarJogo !== 1'b1 || fase !== 4'd1) begin
      n_err++;
      $display("FAIL pre_reset: got estado=%0d reinic=%b fase=%0d expected 1 1 1", estado, ent.reiniciarJogo, fase);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (estado !== 3'd0 || ent.reiniciarJogo !== 1'b0 || ent.pausa !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got estado=%0d reinic=%b pausa=%b expected 0 0 1",
               estado, ent.reiniciarJogo, ent.pausa);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause();
    test_derrota_prioridade();
`ifdef CONTROLE_FASES_EN
    test_fases();
`else
    test_vitoria_sem_fases();
`endif
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
